// File: rtl/prol16_mem_responder.sv
// prol16_mem_responder: word-addressed memory model for a PROL16 CPU with a
// streaming program loader.
//   LOAD : CPU held in reset (cpu_res_o=1), ld_* stream fills memory from 0.
//   RUN  : CPU bus (active-low ce/oe/we) reads with 1-cycle latency / writes.
// Ports
//   clk, rst                      clock, async active-high reset
//   mem_addr_i, mem_data_i        CPU word address and write data
//   mem_data_o                    registered read data
//   mem_ce_ni/mem_oe_ni/mem_we_ni CPU active-low strobes
//   ld_start_i                    request (re)entry into LOAD
//   ld_valid_i/ld_data_i/ld_last_i load stream; ld_ready_o high in LOAD
//   cpu_res_o                     CPU reset, high while loading
//   bus_err_o                     sticky protocol / range error
// Optional feature: define PROL16_MEM_RANGE_CHECK_EN to reject RUN accesses
// with address bits set at or above gAddrBits (read returns 0, error set);
// otherwise such addresses alias modulo the memory depth.
module prol16_mem_responder #(
  parameter int unsigned gDataWidth = 16,
  parameter int unsigned gAddrBits  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [gDataWidth-1:0] mem_addr_i,
  input  logic [gDataWidth-1:0] mem_data_i,
  output logic [gDataWidth-1:0] mem_data_o,
  input  logic                  mem_ce_ni,
  input  logic                  mem_oe_ni,
  input  logic                  mem_we_ni,
  input  logic                  ld_start_i,
  input  logic                  ld_valid_i,
  input  logic [gDataWidth-1:0] ld_data_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  output logic                  cpu_res_o,
  output logic                  bus_err_o
);

  localparam int unsigned DEPTH = 2 ** gAddrBits;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [gAddrBits-1:0]  r_ptr;
  logic [gDataWidth-1:0] r_mem [DEPTH];

  logic                  w_ld_we;
  logic                  w_cpu_rd;
  logic                  w_cpu_wr;
  logic                  w_proto_err;
  logic [gAddrBits-1:0]  w_addr;
  logic                  w_addr_oob;
  logic                  w_unused_addr_hi;

  assign w_addr           = mem_addr_i[gAddrBits-1:0];
  assign w_unused_addr_hi = |mem_addr_i[gDataWidth-1:gAddrBits];

`ifdef PROL16_MEM_RANGE_CHECK_EN
  assign w_addr_oob = w_unused_addr_hi;
`else
  assign w_addr_oob = 1'b0;
`endif

  // State decodes are the CPU reset and loader handshake
  assign ld_ready_o = (r_state == ST_LOAD);
  assign cpu_res_o  = (r_state == ST_LOAD);

  // Next state and per-cycle access decode
  always_comb begin
    w_state_next = r_state;
    w_ld_we      = 1'b0;
    w_cpu_rd     = 1'b0;
    w_cpu_wr     = 1'b0;
    w_proto_err  = 1'b0;
    case (r_state)
      ST_LOAD: begin
        // ld_start_i restarts the pointer and drops any concurrent word
        if (!ld_start_i && ld_valid_i) begin
          w_ld_we = 1'b1;
          if (ld_last_i || (r_ptr == gAddrBits'(DEPTH - 1))) begin
            w_state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (ld_start_i) begin
          w_state_next = ST_LOAD;
        end
        if (!mem_ce_ni) begin
          case ({mem_oe_ni, mem_we_ni})
            2'b01:   w_cpu_rd    = 1'b1;
            2'b10:   w_cpu_wr    = 1'b1;
            2'b00:   w_proto_err = 1'b1;
            default: ;
          endcase
        end
      end
      default: w_state_next = ST_LOAD;
    endcase
  end

  // State, load pointer, read data and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_LOAD;
      r_ptr      <= '0;
      mem_data_o <= '0;
      bus_err_o  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((w_state_next != r_state) || (r_state == ST_LOAD && ld_start_i)) begin
        r_ptr <= '0;
      end else if (w_ld_we) begin
        r_ptr <= r_ptr + gAddrBits'(1);
      end
      if (w_cpu_rd) begin
        mem_data_o <= w_addr_oob ? '0 : r_mem[w_addr];
      end
      if (w_proto_err || ((w_cpu_rd || w_cpu_wr) && w_addr_oob)) begin
        bus_err_o <= 1'b1;
      end
    end
  end

  // Memory array survives reset; loader and CPU never write in the same cycle
  always_ff @(posedge clk) begin
    if (w_ld_we) begin
      r_mem[r_ptr] <= ld_data_i;
    end else if (w_cpu_wr && !w_addr_oob) begin
      r_mem[w_addr] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_prol16_mem_responder.sv
// Testbench for prol16_mem_responder: directed loader / CPU bus sequences with
// a queue of expected read data checked one cycle after each read request.
module tb_prol16_mem_responder;

  localparam int unsigned DW    = 16;
  localparam int unsigned AB    = 10;
  localparam int unsigned DEPTH = 2 ** AB;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ce_n;
  logic          mem_oe_n;
  logic          mem_we_n;
  logic          ld_start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          cpu_res;
  logic          bus_err;

  int unsigned   n_pass  = 0;
  int unsigned   n_total = 0;
  logic [DW-1:0] exp_q [$];

  prol16_mem_responder #(
    .gDataWidth(DW),
    .gAddrBits (AB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr_i (mem_addr),
    .mem_data_i (mem_wdata),
    .mem_data_o (mem_rdata),
    .mem_ce_ni  (mem_ce_n),
    .mem_oe_ni  (mem_oe_n),
    .mem_we_ni  (mem_we_n),
    .ld_start_i (ld_start),
    .ld_valid_i (ld_valid),
    .ld_data_i  (ld_data),
    .ld_last_i  (ld_last),
    .ld_ready_o (ld_ready),
    .cpu_res_o  (cpu_res),
    .bus_err_o  (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mem_ce_n = 1'b1;
    mem_oe_n = 1'b1;
    mem_we_n = 1'b1;
  endtask

  task automatic load_word(input logic [DW-1:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic cpu_write(input logic [DW-1:0] a, input logic [DW-1:0] d);
    mem_addr  = a;
    mem_wdata = d;
    mem_ce_n  = 1'b0;
    mem_oe_n  = 1'b1;
    mem_we_n  = 1'b0;
    tick();
    bus_idle();
  endtask

  task automatic cpu_read(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] e);
    exp_q.push_back(e);
    mem_addr = a;
    mem_ce_n = 1'b0;
    mem_oe_n = 1'b0;
    mem_we_n = 1'b1;
    tick();
    bus_idle();
    if (exp_q.size() == 0) check({tag, "_noexp"}, 32'd1, 32'd0);
    else check(tag, 32'(mem_rdata), 32'(exp_q.pop_front()));
  endtask

  initial begin
    rst = 1'b0; mem_addr = '0; mem_wdata = '0; bus_idle();
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_cpu_res", 32'(cpu_res), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_rdata", 32'(mem_rdata), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Three-word load terminated by ld_last
    load_word(16'h1111, 1'b0);
    load_word(16'h2222, 1'b0);
    check("load2_cpu_res", 32'(cpu_res), 32'd1);
    load_word(16'h3333, 1'b1);
    check("load3_cpu_res", 32'(cpu_res), 32'd0);
    check("load3_ld_ready", 32'(ld_ready), 32'd0);
    cpu_read("rd0", 16'd0, 16'h1111);
    cpu_read("rd1", 16'd1, 16'h2222);
    cpu_read("rd2", 16'd2, 16'h3333);

    // Write then back-to-back read, then idle holds data
    cpu_write(16'd5, 16'hBEEF);
    cpu_read("rd5_after_wr", 16'd5, 16'hBEEF);
    tick();
    check("idle_hold", 32'(mem_rdata), 32'hBEEF);
    mem_ce_n = 1'b0;
    tick();
    bus_idle();
    check("ce_idle_hold", 32'(mem_rdata), 32'hBEEF);

    // Out-of-range address handling
    cpu_write(16'd5, 16'hA5A5);
`ifdef PROL16_MEM_RANGE_CHECK_EN
    cpu_read("rd_oob", 16'h0405, 16'h0000);
    check("oob_bus_err", 32'(bus_err), 32'd1);
`else
    cpu_read("rd_alias", 16'h0405, 16'hA5A5);
    check("alias_bus_err", 32'(bus_err), 32'd0);
`endif

    // Protocol error: ce=oe=we=0
    mem_addr = 16'd2; mem_wdata = 16'hDEAD;
    mem_ce_n = 1'b0; mem_oe_n = 1'b0; mem_we_n = 1'b0;
    tick();
    bus_idle();
    check("proto_bus_err", 32'(bus_err), 32'd1);
    cpu_read("rd2_after_err", 16'd2, 16'h3333);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("start_cpu_res", 32'(cpu_res), 32'd1);
    check("start_bus_err_sticky", 32'(bus_err), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_clears_err", 32'(bus_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Full-depth load without ld_last
    for (int i = 0; i < int'(DEPTH); i++) begin
      load_word(16'h4000 + 16'(i), 1'b0);
      if (i == int'(DEPTH) - 2) check("full_pre_cpu_res", 32'(cpu_res), 32'd1);
    end
    check("full_cpu_res", 32'(cpu_res), 32'd0);
    cpu_read("full_rd_last", 16'(DEPTH - 1), 16'h4000 + 16'(DEPTH - 1));
    cpu_read("full_rd_3", 16'd3, 16'h4003);

    // Reload interrupted by reset after two words
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    load_word(16'h7001, 1'b0);
    load_word(16'h7002, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_cpu_res", 32'(cpu_res), 32'd1);
    check("rst_mid_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    rst = 1'b0;
    // ld_start with a concurrent word drops the word
    ld_start = 1'b1;
    load_word(16'hDEAD, 1'b0);
    ld_start = 1'b0;
    load_word(16'h7100, 1'b1);
    check("reload_cpu_res", 32'(cpu_res), 32'd0);
    cpu_read("reload_rd0", 16'd0, 16'h7100);
    cpu_read("reload_rd1", 16'd1, 16'h7002);
    cpu_read("reload_rd2", 16'd2, 16'h4002);
    cpu_read("reload_rd1000", 16'd1000, 16'h4000 + 16'd1000);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
